// File: rtl/cv32e40p_instr_realigner.sv
// Instruction realigner: turns a word-aligned fetch stream into whole RV32 instructions
// (32-bit or zero-extended compressed) and tracks the PC of the presented instruction.
module cv32e40p_instr_realigner (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_aligned_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i
);

  typedef enum logic [1:0] {Aligned, Misaligned, BranchMis} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] half_q, half_d;
  logic        valid;
  logic        ready;
  logic        accept;

  assign accept = valid && id_ready_i;

  always_comb begin
    valid           = 1'b0;
    ready           = 1'b0;
    instr_aligned_o = fetch_rdata_i;
    state_d         = state_q;
    pc_d            = pc_q;
    half_d          = half_q;

    unique case (state_q)
      Aligned: begin
        valid = fetch_valid_i;
        if (fetch_rdata_i[1:0] == 2'b11) begin
          instr_aligned_o = fetch_rdata_i;
          if (accept) begin
            pc_d  = pc_q + 32'd4;
            ready = 1'b1;
          end
        end else begin
          instr_aligned_o = {16'h0, fetch_rdata_i[15:0]};
          if (accept) begin
            pc_d    = pc_q + 32'd2;
            ready   = 1'b1;
            half_d  = fetch_rdata_i[31:16];
            state_d = Misaligned;
          end
        end
      end
      Misaligned: begin
        if (half_q[1:0] != 2'b11) begin
          // Stashed compressed instruction issues without needing a new word.
          valid           = 1'b1;
          instr_aligned_o = {16'h0, half_q};
          if (accept) begin
            pc_d    = pc_q + 32'd2;
            state_d = Aligned;
          end
        end else begin
          valid           = fetch_valid_i;
          instr_aligned_o = {fetch_rdata_i[15:0], half_q};
          if (accept) begin
            pc_d   = pc_q + 32'd4;
            ready  = 1'b1;
            half_d = fetch_rdata_i[31:16];
          end
        end
      end
      BranchMis: begin
        instr_aligned_o = {16'h0, fetch_rdata_i[31:16]};
        if (fetch_rdata_i[17:16] != 2'b11) begin
          valid = fetch_valid_i;
          if (accept) begin
            pc_d    = pc_q + 32'd2;
            ready   = 1'b1;
            state_d = Aligned;
          end
        end else if (fetch_valid_i) begin
          // Upper half starts a 32-bit instruction: stash it, costing one bubble.
          ready   = 1'b1;
          half_d  = fetch_rdata_i[31:16];
          state_d = Misaligned;
        end
      end
      default: begin
        state_d = Aligned;
      end
    endcase

    if (branch_i) begin
      valid   = 1'b0;
      ready   = 1'b0;
      pc_d    = {branch_addr_i[31:1], 1'b0};
      state_d = branch_addr_i[1] ? BranchMis : Aligned;
    end
  end

  assign instr_valid_o = valid;
  assign fetch_ready_o = ready && !rst;
  assign pc_o          = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Aligned;
      pc_q    <= 32'h0;
      half_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      half_q  <= half_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_instr_realigner.sv
// Scoreboard bench for cv32e40p_instr_realigner: directed fetch words, expected
// (instr, pc) pairs queued by stimulus and checked by a monitor on each accept.
module tb_cv32e40p_instr_realigner;

  logic        clk;
  logic        rst;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_aligned_o;
  logic [31:0] pc_o;
  logic        id_ready_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  cv32e40p_instr_realigner dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_rdata_i   (fetch_rdata_i),
    .fetch_ready_o   (fetch_ready_o),
    .instr_valid_o   (instr_valid_o),
    .instr_aligned_o (instr_aligned_o),
    .pc_o            (pc_o),
    .id_ready_i      (id_ready_i),
    .branch_i        (branch_i),
    .branch_addr_i   (branch_addr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && instr_valid_o === 1'b1 && id_ready_i) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_instr: got %08h at pc %08h, expected none", instr_aligned_o,
                 pc_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instr_aligned_o, e.instr);
        chk("sb_pc", pc_o, e.pc);
      end
    end
  end

  task automatic drive(input logic fv, input logic [31:0] rd, input logic idr,
                       input logic br, input logic [31:0] ba);
    fetch_valid_i = fv;
    fetch_rdata_i = rd;
    id_ready_i    = idr;
    branch_i      = br;
    branch_addr_i = ba;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    sb.push_back('{instr: instr, pc: pc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_branch(input logic [31:0] addr);
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, addr);
    @(negedge clk);
    chk("branch_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("branch_ready", {31'h0, fetch_ready_o}, 32'h0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("rst_ready", {31'h0, fetch_ready_o}, 32'h0);
    step();
    rst = 1'b0;

    // Two aligned 32-bit instructions.
    push(32'h0000_0013, 32'h0);
    drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("a32_ready0", {31'h0, fetch_ready_o}, 32'h1);
    step();
    push(32'h0010_0093, 32'h4);
    drive(1'b1, 32'h0010_0093, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("a32_ready1", {31'h0, fetch_ready_o}, 32'h1);
    step();

    // Two compressed in one word; second issues from the stash without a fetch.
    do_branch(32'h0);
    push(32'h0000_4501, 32'h0);
    drive(1'b1, 32'h4501_4501, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("cc_ready0", {31'h0, fetch_ready_o}, 32'h1);
    step();
    push(32'h0000_4501, 32'h2);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("cc_valid1", {31'h0, instr_valid_o}, 32'h1);
    chk("cc_ready1", {31'h0, fetch_ready_o}, 32'h0);
    step();

    // PC wrap: halfword target at top of memory.
    do_branch(32'hFFFF_FFFF);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFE);
    push(32'h0000_4501, 32'hFFFF_FFFE);
    drive(1'b1, 32'h4501_0000, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("wrap_ready", {31'h0, fetch_ready_o}, 32'h1);
    step();
    push(32'h0000_0013, 32'h0);
    drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    step();

    // Straddling 32-bit instruction.
    do_branch(32'h0);
    push(32'h0000_4501, 32'h0);
    drive(1'b1, 32'h0013_4501, 1'b1, 1'b0, 32'h0);
    step();
    push(32'h0000_0013, 32'h2);
    drive(1'b1, 32'h4000_0000, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("strad_ready", {31'h0, fetch_ready_o}, 32'h1);
    step();

    // Stall in MISALIGNED with stash 0x4000 at pc 6.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("stall_valid", {31'h0, instr_valid_o}, 32'h1);
      chk("stall_instr", instr_aligned_o, 32'h0000_4000);
      chk("stall_pc", pc_o, 32'h6);
      chk("stall_ready", {31'h0, fetch_ready_o}, 32'h0);
      step();
    end
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0102);
    @(negedge clk);
    chk("stallbr_valid", {31'h0, instr_valid_o}, 32'h0);
    step();
    chk("stallbr_pc", pc_o, 32'h102);

    // Halfword branch target, compressed upper half.
    push(32'h0000_4501, 32'h102);
    drive(1'b1, 32'h4501_1234, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("bm_ready", {31'h0, fetch_ready_o}, 32'h1);
    step();

    // Halfword branch target, 32-bit straddling: one bubble.
    do_branch(32'h0000_0102);
    drive(1'b1, 32'h0093_ABCD, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("bub_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("bub_ready", {31'h0, fetch_ready_o}, 32'h1);
    step();
    chk("bub_pc", pc_o, 32'h102);
    push(32'h0010_0093, 32'h102);
    drive(1'b1, 32'hABCD_0010, 1'b1, 1'b0, 32'h0);
    step();

    // Stash 0xABCD pending at pc 0x106; async reset drops it.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("pre_rst_instr", instr_aligned_o, 32'h0000_ABCD);
    chk("pre_rst_pc", pc_o, 32'h106);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc_o, 32'h0);
    chk("async_rst_valid", {31'h0, instr_valid_o}, 32'h0);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h0000_0013;
    #1;
    chk("async_rst_instr", instr_aligned_o, 32'h0000_0013);
    chk("async_rst_ready", {31'h0, fetch_ready_o}, 32'h0);
    step();
    rst = 1'b0;
    fetch_valid_i = 1'b0;
    step();

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d instrs outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
